// File: rtl/logic_gate_pipe.sv
// WIDTH-bit 8-mode bitwise logic engine behind a stallable DEPTH-stage pipe.
// Optional macro LOGIC_GATE_PIPE_PARITY_EN adds out_parity carried per beat.
module logic_gate_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clr_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       out_mode,
  output logic [CNT_W-1:0] txn_count,
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             ovf
);

  logic [DEPTH-1:0] vld_q, vld_d, mv;
  logic [WIDTH-1:0] res_q [DEPTH];
  logic [WIDTH-1:0] res_d [DEPTH];
  logic [2:0]       mod_q [DEPTH];
  logic [2:0]       mod_d [DEPTH];
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q, par_d;
`endif
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept, hs;
  logic [WIDTH-1:0] new_res;

  function automatic logic [WIDTH-1:0] calc(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (m)
      3'b000: r = ~(a & b);
      3'b001: r = a & b;
      3'b010: r = ~(a | b);
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~(a ^ b);
      3'b110: r = ~a;
      3'b111: r = a;
    endcase
    return r;
  endfunction

  // Walk from the output back: a stage may move if the slot ahead frees up.
  always_comb begin
    logic free;
    free = ena & out_ready;
    mv   = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      mv[k] = vld_q[k] & free;
      free  = ena & (~vld_q[k] | mv[k]);
    end
    in_ready = free;
  end

  assign accept  = in_valid & in_ready;
  assign new_res = calc(mode, op_a, op_b);
  assign hs      = ena & vld_q[DEPTH-1] & out_ready;

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    mod_d = mod_q;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    par_d = par_q;
`endif
    if (accept) begin
      vld_d[0] = 1'b1;
      res_d[0] = new_res;
      mod_d[0] = mode;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      par_d[0] = ^new_res;
`endif
    end else if (mv[0]) begin
      vld_d[0] = 1'b0;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (mv[k-1]) begin
        vld_d[k] = 1'b1;
        res_d[k] = res_q[k-1];
        mod_d[k] = mod_q[k-1];
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        par_d[k] = par_q[k-1];
`endif
      end else if (mv[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  // Clear beats a same-cycle handshake.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (ena & clr_count) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hs) begin
      cnt_d = cnt_q + 1'b1;
      ovf_d = ovf_q | (&cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        res_q[k] <= '0;
        mod_q[k] <= '0;
      end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      par_q <= '0;
`endif
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) begin
        res_q[k] <= res_d[k];
        mod_q[k] <= mod_d[k];
      end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
      par_q <= par_d;
`endif
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign result    = res_q[DEPTH-1];
  assign out_mode  = mod_q[DEPTH-1];
  assign txn_count = cnt_q;
  assign ovf       = ovf_q;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  assign out_parity = par_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Randomized and directed bench for logic_gate_pipe against a queue model.
// Beats carry a slot position; outputs are predicted per cycle.
module tb_logic_gate_pipe;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, ena, clr_count, in_valid, in_ready;
  logic [W-1:0]  op_a, op_b, result;
  logic [2:0]    mode, out_mode;
  logic          out_valid, out_ready, ovf;
  logic [CW-1:0] txn_count;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic          out_parity;
`endif

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clr_count(clr_count),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_mode(out_mode),
    .txn_count(txn_count),
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   m;
    int           pos;
  } beat_t;

  beat_t         q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_cnt;
  logic          m_ovf;
  logic          e_ov, e_ir, hs_p, acc_p, p_en, p_clr;
  logic [W-1:0]  e_res, p_r;
  logic [2:0]    e_mode, p_m;
  int            np [D];
  int            first;

  // Per-mode truth table indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];
  initial begin
    tt[0] = 4'b0111; tt[1] = 4'b1000;
    tt[2] = 4'b0001; tt[3] = 4'b1110;
    tt[4] = 4'b0110; tt[5] = 4'b1001;
    tt[6] = 4'b0011; tt[7] = 4'b1100;
  end

  function automatic logic [W-1:0] ref_op(
    input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   t;
    t = tt[m];
    for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] m,
                       input logic ordy, input logic en, input logic clr);
    int lim, nx;
    @(negedge clk);
    in_valid = iv; op_a = a; op_b = b; mode = m;
    out_ready = ordy; ena = en; clr_count = clr;
    #1;
    e_ov   = (q.size() > 0) && (q[0].pos == D-1);
    e_res  = e_ov ? q[0].r : '0;
    e_mode = e_ov ? q[0].m : '0;
    hs_p   = en && ordy && e_ov;
    first  = hs_p ? 1 : 0;
    lim    = D;
    for (int i = first; i < q.size(); i++) begin
      nx = (en && (q[i].pos + 1 < lim)) ? q[i].pos + 1 : q[i].pos;
      np[i] = nx;
      lim = nx;
    end
    e_ir  = en && (lim > 0);
    acc_p = iv && e_ir;
    p_en  = en; p_clr = clr;
    p_r   = ref_op(m, a, b); p_m = m;
  endtask

  task automatic advance();
    beat_t t;
    @(posedge clk);
    for (int i = first; i < q.size(); i++) begin
      t = q[i]; t.pos = np[i]; q[i] = t;
    end
    if (hs_p) void'(q.pop_front());
    if (acc_p) begin
      t.r = p_r; t.m = p_m; t.pos = 0;
      q.push_back(t);
    end
    if (p_en && p_clr) begin
      m_cnt = '0; m_ovf = 1'b0;
    end else if (hs_p) begin
      if (m_cnt == {CW{1'b1}}) m_ovf = 1'b1;
      m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < D + 2; i++) begin
      drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
      advance();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; clr_count = 1'b0; in_valid = 1'b0;
    op_a = '0; op_b = '0; mode = '0; out_ready = 1'b0;
    q.delete(); m_cnt = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || out_mode !== '0 ||
        txn_count !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%h m=%h c=%h o=%b exp all 0",
               out_valid, result, out_mode, txn_count, ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_nand();
    flush();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b1); advance();
    drive(1'b1, 4'b1100, 4'b1010, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL nand_accept got %b exp 1", in_ready);
    end
    advance();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL nand_early got %b exp 0", out_valid);
    end
    advance();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || result !== 4'b0111 || out_mode !== 3'd0) begin
      errors++;
      $display("FAIL nand_result got v=%b r=%b m=%0d exp v=1 r=0111 m=0",
               out_valid, result, out_mode);
    end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
    checks++;
    if (out_parity !== 1'b1) begin
      errors++; $display("FAIL nand_parity got %b exp 1", out_parity);
    end
`endif
    advance();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (txn_count !== 4'd1) begin
      errors++; $display("FAIL nand_count got %0d exp 1", txn_count);
    end
    advance();
  endtask

  task automatic test_stream();
    logic [W-1:0] exp2 [8];
    exp2[0] = 4'hA; exp2[1] = 4'h5; exp2[2] = 4'h0; exp2[3] = 4'hF;
    exp2[4] = 4'hA; exp2[5] = 4'h5; exp2[6] = 4'h0; exp2[7] = 4'hF;
    flush();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b1); advance();
    for (int c = 0; c < 10; c++) begin
      drive(c < 8, 4'hF, 4'h5, 3'(c), 1'b1, 1'b1, 1'b0);
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready c=%0d got %b exp 1", c, in_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || result !== exp2[c-2] || out_mode !== 3'(c-2)) begin
          errors++;
          $display("FAIL stream_result c=%0d got v=%b r=%h exp v=1 r=%h",
                   c, out_valid, result, exp2[c-2]);
        end
      end
      advance();
    end
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (txn_count !== 4'd8) begin
      errors++; $display("FAIL stream_count got %0d exp 8", txn_count);
    end
    advance();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a [3];
    logic [W-1:0] b [3];
    logic [2:0]   m [3];
    logic         exp_ir [5];
    logic         ordy;
    int           k;
    exp_ir[0] = 1; exp_ir[1] = 1; exp_ir[2] = 0; exp_ir[3] = 0; exp_ir[4] = 1;
    for (int i = 0; i < 3; i++) begin
      a[i] = 4'($urandom); b[i] = 4'($urandom); m[i] = 3'($urandom);
    end
    flush();
    for (int c = 0; c < 7; c++) begin
      k = (c < 2) ? c : 2;
      ordy = (c >= 4);
      drive(c <= 4, a[k], b[k], m[k], ordy, 1'b1, 1'b0);
      if (c <= 4) begin
        checks++;
        if (in_ready !== exp_ir[c] || e_ir !== exp_ir[c]) begin
          errors++;
          $display("FAIL bp_ready c=%0d got %b exp %b", c, in_ready, exp_ir[c]);
        end
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || result !== e_res || out_mode !== e_mode) begin
          errors++;
          $display("FAIL bp_result c=%0d got v=%b r=%h m=%0d exp v=1 r=%h m=%0d",
                   c, out_valid, result, out_mode, e_res, e_mode);
        end
      end
      if (c == 3) begin
        checks++;
        if (result !== ref_op(m[0], a[0], b[0])) begin
          errors++;
          $display("FAIL bp_hold got %h exp %h", result, ref_op(m[0], a[0], b[0]));
        end
      end
      advance();
    end
  endtask

  task automatic test_counter();
    flush();
    drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b1); advance();
    for (int c = 0; c <= 20; c++) begin
      drive(c <= 18, 4'($urandom), 4'($urandom), 3'($urandom),
            1'b1, 1'b1, c == 18);
      checks++;
      if (txn_count !== m_cnt || ovf !== m_ovf) begin
        errors++;
        $display("FAIL cnt_track c=%0d got %0d/%b exp %0d/%b",
                 c, txn_count, ovf, m_cnt, m_ovf);
      end
      if (c == 18) begin
        checks++;
        if (txn_count !== 4'd0 || ovf !== 1'b1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL cnt_wrap got %0d/%b v=%b exp 0/1 v=1",
                   txn_count, ovf, out_valid);
        end
      end
      if (c == 19) begin
        checks++;
        if (txn_count !== 4'd0 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL cnt_clr got %0d/%b exp 0/0", txn_count, ovf);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_inflight();
    flush();
    drive(1'b1, 4'h9, 4'h0, 3'd7, 1'b0, 1'b1, 1'b0); advance();
    drive(1'b1, 4'h6, 4'h3, 3'd1, 1'b0, 1'b1, 1'b0); advance();
    drive(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || result !== 4'h9) begin
      errors++;
      $display("FAIL rst_pre got v=%b r=%h exp v=1 r=9", out_valid, result);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || out_mode !== '0) begin
      errors++;
      $display("FAIL rst_async got v=%b r=%h m=%0d exp 0", out_valid, result, out_mode);
    end
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_cnt = '0; m_ovf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || txn_count !== '0) begin
        errors++;
        $display("FAIL rst_stale c=%0d got v=%b c=%0d exp 0", c, out_valid, txn_count);
      end
      advance();
    end
  endtask

  task automatic test_ena();
    logic [CW-1:0] frozen;
    logic          en;
    flush();
    for (int c = 0; c < 12; c++) begin
      en = !(c >= 4 && c < 7);
      if (c == 3)
        drive(1'b1, 4'b1100, 4'b1010, 3'd0, 1'b1, en, 1'b0);
      else
        drive(c < 9, 4'($urandom), 4'($urandom), 3'($urandom), 1'b1, en, 1'b0);
      if (c == 4) frozen = txn_count;
      checks++;
      if (in_ready !== e_ir || out_valid !== e_ov) begin
        errors++;
        $display("FAIL ena_hs c=%0d got r=%b v=%b exp r=%b v=%b",
                 c, in_ready, out_valid, e_ir, e_ov);
      end
      if (e_ov) begin
        checks++;
        if (result !== e_res || out_mode !== e_mode) begin
          errors++;
          $display("FAIL ena_result c=%0d got %h/%0d exp %h/%0d",
                   c, result, out_mode, e_res, e_mode);
        end
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        checks++;
        if (out_parity !== ^e_res) begin
          errors++;
          $display("FAIL ena_parity c=%0d got %b exp %b", c, out_parity, ^e_res);
        end
`endif
      end
      if (c >= 4 && c <= 7) begin
        checks++;
        if (txn_count !== m_cnt || in_ready !== 1'b0 && c < 7) begin
          errors++;
          $display("FAIL ena_frozen c=%0d got %0d exp %0d", c, txn_count, m_cnt);
        end
        if (c == 7) begin
          checks++;
          if (txn_count !== frozen) begin
            errors++;
            $display("FAIL ena_count got %0d exp %0d", txn_count, frozen);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic iv, ordy, en, clr;
    flush();
    for (int c = 0; c < 300; c++) begin
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      en   = ($urandom % 8) != 0;
      clr  = ($urandom % 32) == 0;
      drive(iv, 4'($urandom), 4'($urandom), 3'($urandom), ordy, en, clr);
      checks++;
      if (in_ready !== e_ir || out_valid !== e_ov) begin
        errors++;
        $display("FAIL rnd_hs c=%0d got r=%b v=%b exp r=%b v=%b",
                 c, in_ready, out_valid, e_ir, e_ov);
      end
      if (e_ov) begin
        checks++;
        if (result !== e_res || out_mode !== e_mode) begin
          errors++;
          $display("FAIL rnd_result c=%0d got %h/%0d exp %h/%0d",
                   c, result, out_mode, e_res, e_mode);
        end
      end
      checks++;
      if (txn_count !== m_cnt || ovf !== m_ovf) begin
        errors++;
        $display("FAIL rnd_count c=%0d got %0d/%b exp %0d/%b",
                 c, txn_count, ovf, m_cnt, m_ovf);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_stream();
    test_backpressure();
    test_counter();
    test_reset_inflight();
    test_ena();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
Parametrised successor to the single fixed NAND gate: a WIDTH-bit, 8-mode bitwise logic engine, with NAND as mode 0.
- Operands enter through a valid/ready handshake and pass through a DEPTH-stage stallable pipeline.
- Results leave through a valid/ready output with a completed-transaction counter.
- Sits behind the tt_um top-level wrapper; ui_in/uio_in/uo_out are mapped onto its ports by that wrapper.

Parameters:
- WIDTH, 4, operand/result bit width (1..8).
- DEPTH, 2, pipeline stages between input accept and output (1..4).
- CNT_W, 8, width of the transaction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ena  in  1  enable. Low freezes all state.
- clr_count  in  1  synchronous clear of txn_count and ovf.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- mode  in  3  operation select, sampled with the beat.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  computed value.
- out_mode  out  3  mode that produced result.
- txn_count  out  CNT_W  number of completed output handshakes.
- ovf  out  1  sticky; set when txn_count wraps.

Behaviour:
- Reset (async, rst=1): every stage valid=0, result=0, out_mode=0, out_valid=0, txn_count=0, ovf=0. In-flight beats are discarded. in_ready=1 after rst deasserts (if ena=1).
- Modes (bitwise over WIDTH):
  - 000 NAND ~(a&b)
  - 001 AND
  - 010 NOR
  - 011 OR
  - 100 XOR
  - 101 XNOR
  - 110 ~a (b ignored)
  - 111 a pass-through
- Computation: combinational on accept. The value is stored in stage 0 together with its mode.
- Input acceptance: a beat is accepted when in_valid & in_ready at the clock edge.
- Stage advance: stage k (k<DEPTH-1) moves to k+1 when stage k+1 is empty or stage k+1 is itself moving.
- Output drain: the last stage drains when out_valid & out_ready.
- Backpressure: in_ready = ena & (~stage0.valid | stage0 moving). This gives full throughput of 1 beat/cycle with no bubbles under continuous out_ready=1.
- Latency: a beat accepted at edge N appears on out_valid/result after edge N+DEPTH-1, i.e. visible DEPTH-1 cycles later. DEPTH=1 means result is valid in the cycle after accept.
- Output stability: while out_valid=1 and out_ready=0, result and out_mode hold stable.
- Full pipeline: DEPTH beats stored, out_ready=0, gives in_ready=0. Full with out_ready=1 allows accept and drain in the same cycle.
- ena=0: no stage moves, no accept (in_ready=0), no count change. out_valid and result hold. Async reset still acts.
- Counter: txn_count += 1 on each output handshake, wrapping from 2^CNT_W-1 to 0. The wrap sets ovf, which stays set until rst or clr_count.
- clr_count with a simultaneous handshake: clear wins, giving txn_count=0 and ovf=0. clr_count is honoured only when ena=1.
- mode is captured per beat. Changing mode while beats are in flight does not affect them.

Optional Feature:
LOGIC_GATE_PIPE_PARITY_EN
- Defined: adds output port out_parity (1 bit) = XOR-reduction of the result. It is computed at accept and carried through the pipeline alongside result, with the same hold and reset (0) rules.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
1. WIDTH=4, DEPTH=2, out_ready=1. Accept a=4'b1100, b=4'b1010, mode=000 -> one cycle later out_valid=1, result=4'b0111, out_mode=000, txn_count=1.
2. Stream 8 beats, one per cycle, cycling all modes, with a=4'hF, b=4'h5 -> results A,5,0,F,A,5,0,F on consecutive cycles; in_ready stays 1; txn_count=8.
3. out_ready=0 with 3 beats offered -> 2 accepted, in_ready=0 on the third. result holds the first beat's value. Raising out_ready drains in order, and the third beat is accepted in that cycle.
4. CNT_W=2, 5 handshakes -> txn_count sequence 1,2,3,0,1 and ovf=1 from the 4th. clr_count asserted together with the 6th handshake -> txn_count=0, ovf=0.
5. Pulse rst with 2 beats in flight -> out_valid=0 and result=0 immediately (async); no stale beat emerges afterwards.
6. ena=0 for 3 cycles mid-stream with out_ready=1 -> no output changes and txn_count frozen. Resume gives results in original order. With LOGIC_GATE_PIPE_PARITY_EN, result 4'b0111 gives out_parity=1.
